// File: rtl/spin_payout.sv
// spin_payout: turns a stop press into a classified payout for the bank.
// Waits for the reels to settle, captures the four BCD digits and the bet,
// classifies the result, multiplies and holds the payout until it is acked.
// Optional macro SPIN_PAYOUT_STREAK_EN adds a win-streak counter and a
// doubled payout once the streak reaches three.
//
// state      | meaning
// -----------+---------------------------------------------------
// S_IDLE     | waiting for a stop rise
// S_SETTLE   | counting down while the reels come to rest
// S_CAPTURE  | registering reel digits and bet
// S_CLASSIFY | counting equal digit pairs, choosing a multiplier
// S_MULT     | forming the payout, raising payout_valid
// S_PRESENT  | holding the payout until the bank acks
// S_WAIT_REL | waiting for stop to be released (one spin per press)
module spin_payout #(
    parameter logic [7:0] SETTLE_CYCLES = 8'd4,
    parameter logic [3:0] JACKPOT_DIGIT = 4'd7,
    parameter logic [9:0] MULT_PAIR     = 10'd1,
    parameter logic [9:0] MULT_TWO_PAIR = 10'd2,
    parameter logic [9:0] MULT_THREE    = 10'd5,
    parameter logic [9:0] MULT_FOUR     = 10'd20,
    parameter logic [9:0] MULT_JACKPOT  = 10'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic [3:0]  reel1,
    input  logic [3:0]  reel2,
    input  logic [3:0]  reel3,
    input  logic [3:0]  reel4,
    input  logic [7:0]  bet,
    output logic [26:0] payout,
    output logic        payout_valid,
    input  logic        payout_ack,
    output logic [2:0]  win_class,
`ifdef SPIN_PAYOUT_STREAK_EN
    output logic [3:0]  win_streak,
`endif
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_CLASSIFY,
        S_MULT,
        S_PRESENT,
        S_WAIT_REL
    } state_t;

    localparam logic [2:0] CLS_NONE     = 3'd0;
    localparam logic [2:0] CLS_PAIR     = 3'd1;
    localparam logic [2:0] CLS_TWO_PAIR = 3'd2;
    localparam logic [2:0] CLS_THREE    = 3'd3;
    localparam logic [2:0] CLS_FOUR     = 3'd4;
    localparam logic [2:0] CLS_JACKPOT  = 3'd5;
    localparam logic [2:0] CLS_INVALID  = 3'd7;

    state_t      state, state_nxt;
    logic        stop_q;
    logic        stop_rise;
    logic [7:0]  settle_cnt;
    logic [3:0]  d1, d2, d3, d4;
    logic [7:0]  bet_q;
    logic [2:0]  class_q;
    logic [9:0]  mult_q;
    logic [5:0]  eq;
    logic [2:0]  pair_cnt;
    logic        digit_bad;
    logic [2:0]  class_c;
    logic [9:0]  mult_c;
    logic [17:0] product;
    logic [26:0] payout_c;

    assign stop_rise = stop & ~stop_q;
    assign busy      = (state != S_IDLE);
    assign product   = 18'(bet_q) * 18'(mult_q);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (stop_rise) state_nxt = S_SETTLE;
            // leave when the count is about to reach zero so SETTLE lasts
            // exactly SETTLE_CYCLES cycles
            S_SETTLE:   if (settle_cnt <= 8'd1) state_nxt = S_CAPTURE;
            S_CAPTURE:  state_nxt = S_CLASSIFY;
            S_CLASSIFY: state_nxt = S_MULT;
            S_MULT:     state_nxt = S_PRESENT;
            S_PRESENT:  if (payout_ack) state_nxt = S_WAIT_REL;
            S_WAIT_REL: if (!stop) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // pair counting and multiplier selection on the captured digits
    always_comb begin
        eq        = {d1 == d2, d1 == d3, d1 == d4, d2 == d3, d2 == d4, d3 == d4};
        pair_cnt  = {2'b0, eq[0]} + {2'b0, eq[1]} + {2'b0, eq[2]} +
                    {2'b0, eq[3]} + {2'b0, eq[4]} + {2'b0, eq[5]};
        digit_bad = (d1 > 4'd9) || (d2 > 4'd9) || (d3 > 4'd9) || (d4 > 4'd9);
        class_c   = CLS_NONE;
        mult_c    = 10'd0;
        if (digit_bad) begin
            class_c = CLS_INVALID;
            mult_c  = 10'd0;
        end else begin
            case (pair_cnt)
                3'd6: begin
                    if (d1 == JACKPOT_DIGIT) begin
                        class_c = CLS_JACKPOT;
                        mult_c  = MULT_JACKPOT;
                    end else begin
                        class_c = CLS_FOUR;
                        mult_c  = MULT_FOUR;
                    end
                end
                3'd3: begin
                    class_c = CLS_THREE;
                    mult_c  = MULT_THREE;
                end
                3'd2: begin
                    class_c = CLS_TWO_PAIR;
                    mult_c  = MULT_TWO_PAIR;
                end
                3'd1: begin
                    class_c = CLS_PAIR;
                    mult_c  = MULT_PAIR;
                end
                default: begin
                    class_c = CLS_NONE;
                    mult_c  = 10'd0;
                end
            endcase
        end
    end

    // payout value, doubled on a running streak when that feature is built
    always_comb begin
        payout_c = {9'b0, product};
`ifdef SPIN_PAYOUT_STREAK_EN
        if (win_streak >= 4'd3) payout_c = {8'b0, product, 1'b0};
`endif
    end

    // datapath: edge history, settle timer, capture, result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_q       <= 1'b0;
            settle_cnt   <= 8'd0;
            d1           <= 4'd0;
            d2           <= 4'd0;
            d3           <= 4'd0;
            d4           <= 4'd0;
            bet_q        <= 8'd0;
            class_q      <= CLS_NONE;
            mult_q       <= 10'd0;
            payout       <= 27'd0;
            payout_valid <= 1'b0;
            win_class    <= CLS_NONE;
`ifdef SPIN_PAYOUT_STREAK_EN
            win_streak   <= 4'd0;
`endif
        end else begin
            stop_q <= stop;
            case (state)
                S_IDLE: begin
                    if (stop_rise) settle_cnt <= SETTLE_CYCLES;
                end
                S_SETTLE: begin
                    if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
                end
                S_CAPTURE: begin
                    d1    <= reel1;
                    d2    <= reel2;
                    d3    <= reel3;
                    d4    <= reel4;
                    bet_q <= bet;
                end
                S_CLASSIFY: begin
                    class_q <= class_c;
                    mult_q  <= mult_c;
                end
                S_MULT: begin
                    payout       <= payout_c;
                    win_class    <= class_q;
                    payout_valid <= 1'b1;
                end
                S_PRESENT: begin
                    if (payout_ack) begin
                        payout_valid <= 1'b0;
`ifdef SPIN_PAYOUT_STREAK_EN
                        if (win_class >= CLS_PAIR && win_class <= CLS_JACKPOT) begin
                            if (win_streak != 4'd15) win_streak <= win_streak + 4'd1;
                        end else begin
                            win_streak <= 4'd0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spin_payout.sv
// Scoreboard bench for spin_payout: stimulus pushes the expected payout,
// class and valid-rise cycle; a monitor pops and compares on each
// payout_valid rise and flags any presentation nobody asked for.
module tb_spin_payout;

    localparam int SETTLE = 4;

    typedef struct {
        logic [26:0] pay;
        logic [2:0]  cls;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  reel1 = '0, reel2 = '0, reel3 = '0, reel4 = '0;
    logic [7:0]  bet = '0;
    logic [26:0] payout;
    logic        payout_valid;
    logic        payout_ack = 1'b0;
    logic [2:0]  win_class;
    logic        busy;
`ifdef SPIN_PAYOUT_STREAK_EN
    logic [3:0]  win_streak;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   st_model = 0;
    logic prev_v   = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    spin_payout dut (
        .clk          (clk),
        .rst          (rst),
        .stop         (stop),
        .reel1        (reel1),
        .reel2        (reel2),
        .reel3        (reel3),
        .reel4        (reel4),
        .bet          (bet),
        .payout       (payout),
        .payout_valid (payout_valid),
        .payout_ack   (payout_ack),
        .win_class    (win_class),
`ifdef SPIN_PAYOUT_STREAK_EN
        .win_streak   (win_streak),
`endif
        .busy         (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare each new presentation against the scoreboard head
    always @(negedge clk) begin
        if (rst && payout_valid && !prev_v) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("payout", 32'(payout), 32'(mon_e.pay));
                check("win_class", 32'(win_class), 32'(mon_e.cls));
                check("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        prev_v <= payout_valid;
    end

    // mode 0: stop held through ack
    // mode 1: stop re-rises in SETTLE, stray ack in SETTLE, stop low at ack
    // mode 2: stop re-rises in PRESENT, extra acks while stop stays high
    task automatic run_vec(input int r1, input int r2, input int r3, input int r4,
                           input int b, input int cls, input int base, input int mode);
        exp_t e;
        bit   seen;
        int   exp_pay;
        exp_pay = base;
`ifdef SPIN_PAYOUT_STREAK_EN
        if (st_model >= 3) exp_pay = base * 2;
`endif
        @(negedge clk);
        reel1 = 4'(r1); reel2 = 4'(r2); reel3 = 4'(r3); reel4 = 4'(r4);
        bet   = 8'(b);
        e.pay = 27'(exp_pay);
        e.cls = 3'(cls);
        e.cyc = cyc + 1 + SETTLE + 3;
        sb.push_back(e);
        stop = 1'b1;
        if (mode == 1) begin
            @(negedge clk);
            payout_ack = 1'b1;
            @(negedge clk);
            payout_ack = 1'b0;
            stop = 1'b0;
            @(negedge clk);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (payout_valid) begin
                seen = 1;
                break;
            end
        end
        check("valid_seen", 32'(seen), 32'd1);
        if (mode == 2) begin
            stop = 1'b0;
            @(negedge clk);
            stop = 1'b1;
        end
        @(negedge clk);
        check("valid_hold", 32'(payout_valid), 32'd1);
        payout_ack = 1'b1;
        @(negedge clk);
        payout_ack = 1'b0;
        check("valid_drop", 32'(payout_valid), 32'd0);
        check("payout_kept", 32'(payout), 32'(exp_pay));
        check("class_kept", 32'(win_class), 32'(cls));
        if (cls >= 1 && cls <= 5) st_model = (st_model < 15) ? st_model + 1 : 15;
        else                      st_model = 0;
`ifdef SPIN_PAYOUT_STREAK_EN
        check("win_streak", 32'(win_streak), 32'(st_model));
`endif
        check("busy_wait_rel", 32'(busy), 32'd1);
        if (mode == 2) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                payout_ack = 1'b1;
                @(negedge clk);
                payout_ack = 1'b0;
            end
            repeat (8) @(negedge clk);
            check("no_second_eval", 32'(busy), 32'd1);
            check("no_second_valid", 32'(payout_valid), 32'd0);
        end
        stop = 1'b0;
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check("rst_payout", 32'(payout), 32'd0);
        check("rst_valid", 32'(payout_valid), 32'd0);
        check("rst_class", 32'(win_class), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef SPIN_PAYOUT_STREAK_EN
        check("rst_streak", 32'(win_streak), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_vec(3, 3, 3, 3, 10, 4, 200, 0);
        run_vec(7, 7, 7, 7, 2, 5, 200, 2);
        run_vec(5, 5, 5, 1, 4, 3, 20, 1);
        run_vec(1, 1, 2, 2, 9, 2, 18, 0);
        run_vec(1, 2, 3, 4, 7, 0, 0, 0);
        run_vec(11, 1, 1, 1, 5, 7, 0, 0);
        run_vec(2, 2, 2, 2, 0, 4, 0, 0);

        // reset while the payout is being formed: nothing may be presented
        @(negedge clk);
        reel1 = 4'd9; reel2 = 4'd9; reel3 = 4'd9; reel4 = 4'd9; bet = 8'd50;
        stop = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(payout_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_payout", 32'(payout), 32'd0);
        st_model = 0;
        stop = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(payout_valid), 32'd0);

        run_vec(1, 2, 1, 3, 10, 1, 10, 0);
        run_vec(0, 9, 9, 8, 10, 1, 10, 0);
        run_vec(6, 5, 4, 6, 10, 1, 10, 0);
        run_vec(8, 8, 2, 3, 10, 1, 10, 0);
        run_vec(1, 2, 3, 4, 10, 0, 0, 0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spin_payout.md
Name: spin_payout

Overview:
- Downstream of the reel random generator, upstream of the bank.
- When the player's stop (pause) request rises, the block waits for the reels to settle and captures the four BCD reel digits.
- It classifies the result, computes payout = bet × multiplier, and presents it to the bank on a valid/ack handshake.
- Runs on the master clock; the reels advance on the slower slot clock, which is why the settle delay exists.

Parameters:
- SETTLE_CYCLES, 4: master-clock cycles to wait after the stop edge before capturing the reels (1..255).
- JACKPOT_DIGIT, 7: digit value that upgrades four-of-a-kind to jackpot.
- MULT_PAIR, 1: multiplier for exactly one matching pair.
- MULT_TWO_PAIR, 2: multiplier for two distinct pairs.
- MULT_THREE, 5: multiplier for three of a kind.
- MULT_FOUR, 20: multiplier for four of a kind (non-jackpot).
- MULT_JACKPOT, 100: multiplier for four of JACKPOT_DIGIT.
- Multipliers are 10-bit unsigned.

Ports:
- clk  in  1  master clock, 50 MHz.
- rst  in  1  asynchronous active-low reset.
- stop  in  1  debounced pause level; a rising edge requests evaluation.
- reel1, reel2, reel3, reel4  in  4 each  BCD reel digits from the random generator.
- bet  in  8  unsigned wager, sampled at capture.
- payout  out  27  bet × multiplier, zero-extended; matches the bank balance width.
- payout_valid  out  1  payout and class are held stable while high.
- payout_ack  in  1  bank accepts payout.
- win_class  out  3  0 none, 1 pair, 2 two-pair, 3 three, 4 four, 5 jackpot, 7 invalid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=0): state IDLE; payout=0, payout_valid=0, win_class=0, busy=0; stop-edge history register cleared to 0.
- Edge detect: stop is registered each cycle. A rise is stop=1 with the previous sample 0. Rises are acted on only in IDLE; all others are ignored.
- IDLE -> SETTLE on a rise. The settle counter loads SETTLE_CYCLES.
- SETTLE: decrement once per cycle. At 0 -> CAPTURE.
- CAPTURE (1 cycle): register reel1..4 and bet -> CLASSIFY.
- CLASSIFY (1 cycle): count equal pairs among the 6 digit pairs.
  - 6 -> four, or jackpot if digit == JACKPOT_DIGIT.
  - 3 -> three.
  - 2 -> two-pair.
  - 1 -> pair.
  - 0 -> none.
  - Any digit > 9 overrides to class 7 with multiplier 0.
  - Then -> MULT.
- MULT (1 cycle): payout = {9'b0, bet × mult}. The 18-bit product is unsigned and cannot overflow. Set payout_valid=1 -> PRESENT.
- Latency: payout_valid rises SETTLE_CYCLES+3 edges after the edge that detects the rise.
- PRESENT: hold payout, win_class and payout_valid until payout_ack=1 is sampled.
  - On that edge: payout_valid=0; payout and win_class keep their values -> WAIT_REL.
  - Class none or invalid still presents a zero payout and requires ack.
  - ack asserted outside PRESENT is ignored.
- WAIT_REL: -> IDLE once stop=0 is sampled. This enforces one evaluation per press.
  - If stop is already 0 at ack, WAIT_REL lasts exactly 1 cycle.
- stop falling during SETTLE..MULT does not abort; evaluation completes.
- bet = 0 gives payout 0 with the correct class.
- Reset mid-operation returns to IDLE immediately. Any pending payout is discarded and never presented.

Optional Feature:
- Macro: SPIN_PAYOUT_STREAK_EN.
- Defined:
  - Adds output win_streak (4 bits, reset 0).
  - Increments, saturating at 15, on each ack of class 1–5.
  - Clears to 0 on ack of class 0 or 7.
  - From streak ≥ 3 (value before the increment), payout is doubled: product shifted left 1, still within 27 bits.
- Undefined: no port, no counter, payout unchanged.

Test Plan:
- Reels 3,3,3,3, bet 10, stop rise -> after SETTLE_CYCLES+3 edges payout_valid=1, payout=200, class 4; ack -> valid drops next edge.
- Reels 7,7,7,7, bet 2 -> payout 200, class 5. Reels 5,5,5,1, bet 4 -> payout 20, class 3.
- Reels 1,1,2,2, bet 9 -> payout 18, class 2. Reels 1,2,3,4 -> payout 0, class 0, ack still required. Reel 4'hB -> class 7, payout 0.
- Hold stop high through ack, toggle ack again -> no second evaluation until stop falls and rises.
- Stop rise in PRESENT or SETTLE -> ignored. rst=0 during MULT -> payout_valid stays 0, busy=0, state IDLE.
- With SPIN_PAYOUT_STREAK_EN: four pair wins at bet 10 -> payouts 10,10,10,20; win_streak 1,2,3,4. Then a loss -> streak 0.
